// File: rtl/tpu_ctrl_pkg.sv
// Shared constants and state encoding for the TPU control blocks
// (tile scheduler and per-tile multiply controller).
package tpu_ctrl_pkg;

    localparam int SYS_ARR      = 16;
    localparam int MAX_OUT_ROWS = 128;
    localparam int MAX_OUT_COLS = 128;
    localparam int MAX_INTERMED = 128;
    localparam int ADDR_WIDTH   = 8;

    localparam int MAX_RT = MAX_OUT_ROWS / SYS_ARR;
    localparam int MAX_CT = MAX_OUT_COLS / SYS_ARR;
    localparam int MAX_KT = MAX_INTERMED / SYS_ARR;

    localparam int RT_W = $clog2(MAX_RT);
    localparam int CT_W = $clog2(MAX_CT);
    localparam int KT_W = $clog2(MAX_KT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } tile_state_e;

endpackage

// File: rtl/tile_addr_gen.sv
// Tile base address generator: turns (i, j, k) plus the latched job
// geometry into weight and data tile base addresses. Addresses are
// registered and only update when a new tile is loaded, so they stay
// stable while a tile command waits for acceptance.
module tile_addr_gen #(
    parameter int SYS_ARR    = 16,
    parameter int RT_W       = 3,
    parameter int CT_W       = 3,
    parameter int KT_W       = 3,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [RT_W-1:0]       row_idx,
    input  logic [CT_W-1:0]       col_idx,
    input  logic [KT_W-1:0]       k_idx,
    input  logic [CT_W:0]         num_col_tiles,
    input  logic [KT_W:0]         num_k_tiles,
    input  logic [ADDR_WIDTH-1:0] weight_base,
    input  logic [ADDR_WIDTH-1:0] data_base,
    output logic [ADDR_WIDTH-1:0] weight_addr,
    output logic [ADDR_WIDTH-1:0] data_addr
);

    logic [ADDR_WIDTH-1:0] w_addr_s;
    logic [ADDR_WIDTH-1:0] d_addr_s;

    // Address arithmetic; all terms are kept at ADDR_WIDTH so the result wraps modulo 2^ADDR_WIDTH.
    always_comb begin
        w_addr_s = weight_base
                 + (ADDR_WIDTH'(k_idx) * ADDR_WIDTH'(num_col_tiles) + ADDR_WIDTH'(col_idx))
                 * ADDR_WIDTH'(SYS_ARR);
        d_addr_s = data_base
                 + (ADDR_WIDTH'(row_idx) * ADDR_WIDTH'(num_k_tiles) + ADDR_WIDTH'(k_idx))
                 * ADDR_WIDTH'(SYS_ARR);
    end

    // Capture the addresses of the tile being loaded; hold them otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            weight_addr <= {ADDR_WIDTH{1'b0}};
            data_addr   <= {ADDR_WIDTH{1'b0}};
        end else if (load) begin
            weight_addr <= w_addr_s;
            data_addr   <= d_addr_s;
        end else begin
            weight_addr <= weight_addr;
            data_addr   <= data_addr;
        end
    end

endmodule

// File: rtl/matmul_tile_scheduler.sv
// Matrix-multiply tile scheduler: walks i (row tiles), j (col tiles),
// k (shared-dimension tiles, innermost) and hands one tile command at a
// time to the multiply controller with a valid/ready handshake, waiting
// for the tile_done pulse before issuing the next one.
module matmul_tile_scheduler #(
    parameter int  SYS_ARR      = tpu_ctrl_pkg::SYS_ARR,
    parameter int  MAX_OUT_ROWS = tpu_ctrl_pkg::MAX_OUT_ROWS,
    parameter int  MAX_OUT_COLS = tpu_ctrl_pkg::MAX_OUT_COLS,
    parameter int  MAX_INTERMED = tpu_ctrl_pkg::MAX_INTERMED,
    parameter int  ADDR_WIDTH   = tpu_ctrl_pkg::ADDR_WIDTH,
    localparam int MAX_RT       = MAX_OUT_ROWS / SYS_ARR,
    localparam int MAX_CT       = MAX_OUT_COLS / SYS_ARR,
    localparam int MAX_KT       = MAX_INTERMED / SYS_ARR,
    localparam int RT_W         = $clog2(MAX_RT),
    localparam int CT_W         = $clog2(MAX_CT),
    localparam int KT_W         = $clog2(MAX_KT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [RT_W:0]         num_row_tiles,
    input  logic [CT_W:0]         num_col_tiles,
    input  logic [KT_W:0]         num_k_tiles,
    input  logic [ADDR_WIDTH-1:0] weight_base,
    input  logic [ADDR_WIDTH-1:0] data_base,
    output logic                  tile_valid,
    input  logic                  tile_ready,
    input  logic                  tile_done,
    output logic [ADDR_WIDTH-1:0] tile_weight_addr,
    output logic [ADDR_WIDTH-1:0] tile_data_addr,
    output logic [RT_W-1:0]       accum_submat_row,
    output logic [CT_W-1:0]       accum_submat_col,
    output logic                  accum_overwrite,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    import tpu_ctrl_pkg::*;

    localparam logic [RT_W:0] RT_CNT_MAX = (RT_W+1)'(MAX_RT);
    localparam logic [CT_W:0] CT_CNT_MAX = (CT_W+1)'(MAX_CT);
    localparam logic [KT_W:0] KT_CNT_MAX = (KT_W+1)'(MAX_KT);

    tile_state_e           state_r, state_s;
    logic [RT_W-1:0]       i_r, i_s;
    logic [CT_W-1:0]       j_r, j_s;
    logic [KT_W-1:0]       k_r, k_s;
    logic [RT_W:0]         nrt_r, nrt_s;
    logic [CT_W:0]         nct_r, nct_s;
    logic [KT_W:0]         nkt_r, nkt_s;
    logic [ADDR_WIDTH-1:0] wbase_r, wbase_s;
    logic [ADDR_WIDTH-1:0] dbase_r, dbase_s;
    logic                  err_s;
    logic                  cfg_ok_s;
    logic                  i_last_s, j_last_s, k_last_s;
    logic                  load_s;

    assign cfg_ok_s = (num_row_tiles != {(RT_W+1){1'b0}}) && (num_row_tiles <= RT_CNT_MAX)
                   && (num_col_tiles != {(CT_W+1){1'b0}}) && (num_col_tiles <= CT_CNT_MAX)
                   && (num_k_tiles   != {(KT_W+1){1'b0}}) && (num_k_tiles   <= KT_CNT_MAX);

    // Counts are at least 1 while a job runs, so count-1 never underflows here.
    assign i_last_s = ({1'b0, i_r} == (nrt_r - (RT_W+1)'(1'b1)));
    assign j_last_s = ({1'b0, j_r} == (nct_r - (CT_W+1)'(1'b1)));
    assign k_last_s = ({1'b0, k_r} == (nkt_r - (KT_W+1)'(1'b1)));

    // A new tile's fields are loaded only on entry to ISSUE, so they stay frozen while stalled.
    assign load_s = (state_s == ST_ISSUE) && (state_r != ST_ISSUE);

    // Next-state, loop-counter and config-latch logic; abort takes priority in every busy state.
    always_comb begin
        state_s = state_r;
        i_s     = i_r;
        j_s     = j_r;
        k_s     = k_r;
        nrt_s   = nrt_r;
        nct_s   = nct_r;
        nkt_s   = nkt_r;
        wbase_s = wbase_r;
        dbase_s = dbase_r;
        err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_ok_s) begin
                        nrt_s   = num_row_tiles;
                        nct_s   = num_col_tiles;
                        nkt_s   = num_k_tiles;
                        wbase_s = weight_base;
                        dbase_s = data_base;
                        i_s     = {RT_W{1'b0}};
                        j_s     = {CT_W{1'b0}};
                        k_s     = {KT_W{1'b0}};
                        state_s = ST_ISSUE;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (tile_ready) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (tile_done) begin
                    if (i_last_s && j_last_s && k_last_s) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_ISSUE;
                        if (!k_last_s) begin
                            k_s = k_r + KT_W'(1'b1);
                        end else begin
                            k_s = {KT_W{1'b0}};
                            if (!j_last_s) begin
                                j_s = j_r + CT_W'(1'b1);
                            end else begin
                                j_s = {CT_W{1'b0}};
                                i_s = i_r + RT_W'(1'b1);
                            end
                        end
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters, latched config and registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= ST_IDLE;
            i_r              <= {RT_W{1'b0}};
            j_r              <= {CT_W{1'b0}};
            k_r              <= {KT_W{1'b0}};
            nrt_r            <= {(RT_W+1){1'b0}};
            nct_r            <= {(CT_W+1){1'b0}};
            nkt_r            <= {(KT_W+1){1'b0}};
            wbase_r          <= {ADDR_WIDTH{1'b0}};
            dbase_r          <= {ADDR_WIDTH{1'b0}};
            tile_valid       <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
            accum_submat_row <= {RT_W{1'b0}};
            accum_submat_col <= {CT_W{1'b0}};
            accum_overwrite  <= 1'b0;
        end else begin
            state_r    <= state_s;
            i_r        <= i_s;
            j_r        <= j_s;
            k_r        <= k_s;
            nrt_r      <= nrt_s;
            nct_r      <= nct_s;
            nkt_r      <= nkt_s;
            wbase_r    <= wbase_s;
            dbase_r    <= dbase_s;
            tile_valid <= (state_s == ST_ISSUE);
            busy       <= (state_s == ST_ISSUE) || (state_s == ST_WAIT);
            done       <= (state_s == ST_DONE);
            err        <= err_s;
            if (load_s) begin
                accum_submat_row <= i_s;
                accum_submat_col <= j_s;
                accum_overwrite  <= (k_s == {KT_W{1'b0}});
            end else begin
                accum_submat_row <= accum_submat_row;
                accum_submat_col <= accum_submat_col;
                accum_overwrite  <= accum_overwrite;
            end
        end
    end

    tile_addr_gen #(
        .SYS_ARR    (SYS_ARR),
        .RT_W       (RT_W),
        .CT_W       (CT_W),
        .KT_W       (KT_W),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk           (clk),
        .reset         (reset),
        .load          (load_s),
        .row_idx       (i_s),
        .col_idx       (j_s),
        .k_idx         (k_s),
        .num_col_tiles (nct_s),
        .num_k_tiles   (nkt_s),
        .weight_base   (wbase_s),
        .data_base     (dbase_s),
        .weight_addr   (tile_weight_addr),
        .data_addr     (tile_data_addr)
    );

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Self-checking bench for matmul_tile_scheduler: a table of jobs driven
// through a common job runner with an expected-tile scoreboard, plus
// hand sequences for stall, abort, start-while-busy and reset mid-job.
module tb_matmul_tile_scheduler;

    logic       clk = 1'b0;
    logic       reset, start, abort, tile_ready, tile_done;
    logic [3:0] num_row_tiles, num_col_tiles, num_k_tiles;
    logic [7:0] weight_base, data_base;
    logic       tile_valid, accum_overwrite, busy, done, err;
    logic [7:0] tile_weight_addr, tile_data_addr;
    logic [2:0] accum_submat_row, accum_submat_col;

    always #5 clk = ~clk;

    matmul_tile_scheduler dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .num_row_tiles    (num_row_tiles),
        .num_col_tiles    (num_col_tiles),
        .num_k_tiles      (num_k_tiles),
        .weight_base      (weight_base),
        .data_base        (data_base),
        .tile_valid       (tile_valid),
        .tile_ready       (tile_ready),
        .tile_done        (tile_done),
        .tile_weight_addr (tile_weight_addr),
        .tile_data_addr   (tile_data_addr),
        .accum_submat_row (accum_submat_row),
        .accum_submat_col (accum_submat_col),
        .accum_overwrite  (accum_overwrite),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    typedef struct packed {
        logic [2:0] i;
        logic [2:0] j;
        logic [2:0] k;
        logic       ovw;
        logic [7:0] wa;
        logic [7:0] da;
    } tile_exp_t;

    typedef struct {
        int         rows;
        int         cols;
        int         ks;
        logic [7:0] wb;
        logic [7:0] db;
        bit         exp_err;
    } job_vec_t;

    tile_exp_t sb_q[$];
    job_vec_t  vecs[12];
    int        n_vec  = 0;
    int        n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference tile order and addresses, straight from the loop nest and address formulas.
    task automatic push_expected(input int rows, input int cols, input int ks,
                                 input logic [7:0] wb, input logic [7:0] db);
        tile_exp_t t;
        for (int i = 0; i < rows; i++) begin
            for (int j = 0; j < cols; j++) begin
                for (int k = 0; k < ks; k++) begin
                    t.i   = 3'(i);
                    t.j   = 3'(j);
                    t.k   = 3'(k);
                    t.ovw = (k == 0);
                    t.wa  = 8'(int'(wb) + (k * cols + j) * 16);
                    t.da  = 8'(int'(db) + (i * ks + k) * 16);
                    sb_q.push_back(t);
                end
            end
        end
    endtask

    task automatic check_tile(input string tag, input tile_exp_t e);
        check({tag, "_row_col_ovw"}, 32'({accum_submat_row, accum_submat_col, accum_overwrite}),
              32'({e.i, e.j, e.ovw}));
        check({tag, "_addrs"}, 32'({tile_weight_addr, tile_data_addr}), 32'({e.wa, e.da}));
    endtask

    task automatic run_err(input int rows, input int cols, input int ks);
        num_row_tiles = 4'(rows);
        num_col_tiles = 4'(cols);
        num_k_tiles   = 4'(ks);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("err_pulse", 32'(err), 32'd1);
        check("err_busy", 32'(busy), 32'd0);
        check("err_valid", 32'(tile_valid), 32'd0);
        cyc();
        check("err_one_cycle", 32'({err, busy, tile_valid}), 32'd0);
    endtask

    // Drives one job: optional stall on the first tile, abort after tile abort_at,
    // and a rejected start pulse while the first tile is outstanding.
    task automatic run_job(input int rows, input int cols, input int ks,
                           input logic [7:0] wb, input logic [7:0] db,
                           input int stall, input int abort_at, input bit busy_start);
        tile_exp_t e;
        int        tiles;
        int        b;
        tiles = 0;
        push_expected(rows, cols, ks, wb, db);
        num_row_tiles = 4'(rows);
        num_col_tiles = 4'(cols);
        num_k_tiles   = 4'(ks);
        weight_base   = wb;
        data_base     = db;
        tile_ready    = (stall == 0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        // Changing the config inputs mid-job must not disturb the running job.
        num_row_tiles = 4'd1;
        num_col_tiles = 4'd3;
        num_k_tiles   = 4'd5;
        weight_base   = ~wb;
        data_base     = ~db;
        check("start_to_valid", 32'(tile_valid), 32'd1);
        check("busy_set", 32'(busy), 32'd1);
        while (sb_q.size() != 0) begin
            b = 0;
            while (!tile_valid && b < 20) begin
                cyc();
                b++;
            end
            if (!tile_valid) begin
                check("valid_timeout", 32'(tile_valid), 32'd1);
                sb_q.delete();
                return;
            end
            e = sb_q.pop_front();
            check_tile($sformatf("tile%0d", tiles), e);
            if (tiles == 0 && stall > 0) begin
                for (int s = 0; s < stall; s++) begin
                    tile_done = (s == 1);
                    cyc();
                    tile_done = 1'b0;
                    check("stall_valid", 32'(tile_valid), 32'd1);
                    check_tile("stall", e);
                end
                tile_ready = 1'b1;
            end
            cyc();
            check("valid_drop", 32'(tile_valid), 32'd0);
            tiles++;
            if (busy_start && tiles == 1) begin
                num_row_tiles = 4'd1;
                num_col_tiles = 4'd1;
                num_k_tiles   = 4'd1;
                start = 1'b1;
                cyc();
                start = 1'b0;
                check("busy_start_ignored", 32'(tile_valid), 32'd0);
                cyc();
                cyc();
            end else begin
                repeat (3) cyc();
            end
            if (tiles == abort_at) begin
                tile_done = 1'b1;
                abort = 1'b1;
                cyc();
                tile_done = 1'b0;
                abort = 1'b0;
                check("abort_outputs", 32'({tile_valid, busy, done}), 32'd0);
                for (int q = 0; q < 4; q++) begin
                    cyc();
                    check("abort_quiet", 32'({tile_valid, busy, done}), 32'd0);
                end
                sb_q.delete();
                return;
            end
            tile_done = 1'b1;
            cyc();
            tile_done = 1'b0;
            if (sb_q.size() == 0) begin
                check("done_pulse", 32'(done), 32'd1);
                check("done_busy_valid", 32'({busy, tile_valid}), 32'd0);
                cyc();
                check("done_one_cycle", 32'({done, busy, tile_valid}), 32'd0);
            end else begin
                check("next_valid_lat", 32'(tile_valid), 32'd1);
                check("no_early_done", 32'(done), 32'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{2, 2, 2, 8'h00, 8'h40, 1'b0};
        vecs[1]  = '{1, 1, 2, 8'hF0, 8'h10, 1'b0};
        vecs[2]  = '{3, 2, 1, 8'h08, 8'h80, 1'b0};
        vecs[3]  = '{1, 3, 3, 8'hC0, 8'hE0, 1'b0};
        vecs[4]  = '{2, 2, 0, 8'h00, 8'h00, 1'b1};
        vecs[5]  = '{0, 1, 1, 8'h00, 8'h00, 1'b1};
        vecs[6]  = '{9, 1, 1, 8'h00, 8'h00, 1'b1};
        vecs[7]  = '{1, 9, 1, 8'h00, 8'h00, 1'b1};
        vecs[8]  = '{1, 1, 9, 8'h00, 8'h00, 1'b1};
        vecs[9]  = '{8, 1, 1, 8'h00, 8'h00, 1'b0};
        vecs[10] = '{1, 1, 8, 8'h00, 8'h00, 1'b0};
        vecs[11] = '{1, 8, 2, 8'h30, 8'h00, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        tile_ready = 1'b0;
        tile_done = 1'b0;
        num_row_tiles = 4'd0;
        num_col_tiles = 4'd0;
        num_k_tiles = 4'd0;
        weight_base = 8'h00;
        data_base = 8'h00;
        repeat (2) cyc();
        reset = 1'b0;
        check("reset_outputs", 32'({tile_valid, busy, done, err, accum_overwrite, accum_submat_row,
              accum_submat_col, tile_weight_addr, tile_data_addr}), 32'd0);
        cyc();
        check("idle_outputs", 32'({tile_valid, busy, done, err}), 32'd0);

        for (int v = 0; v < 12; v++) begin
            if (vecs[v].exp_err) begin
                run_err(vecs[v].rows, vecs[v].cols, vecs[v].ks);
            end else begin
                run_job(vecs[v].rows, vecs[v].cols, vecs[v].ks, vecs[v].wb, vecs[v].db, 0, -1, 1'b0);
            end
            cyc();
        end

        // Weight base wrap: 0xF0 + 1*16 must come out as 0x00 on the second tile.
        push_expected(1, 1, 2, 8'hF0, 8'h00);
        check("wrap_model_second_tile", 32'(sb_q[1].wa), 32'h00);
        sb_q.delete();

        // tile_ready held low: first tile and its fields stay put, tile_done in ISSUE ignored.
        run_job(1, 2, 2, 8'h00, 8'h00, 5, -1, 1'b0);
        cyc();

        // start with different counts while busy: original sequence must complete.
        run_job(2, 1, 2, 8'h10, 8'h20, 0, -1, 1'b1);
        cyc();

        // abort during WAIT of the 3rd tile with tile_done in the same cycle, then restart.
        run_job(2, 2, 2, 8'h00, 8'h40, 0, 3, 1'b0);
        run_job(2, 2, 2, 8'h00, 8'h40, 0, -1, 1'b0);
        cyc();

        // Reset in the middle of a job clears every output.
        num_row_tiles = 4'd2;
        num_col_tiles = 4'd2;
        num_k_tiles = 4'd2;
        weight_base = 8'h50;
        data_base = 8'h60;
        tile_ready = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("pre_reset_valid", 32'(tile_valid), 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("midjob_reset_outputs", 32'({tile_valid, busy, done, err, accum_overwrite, accum_submat_row,
              accum_submat_col, tile_weight_addr, tile_data_addr}), 32'd0);
        cyc();
        check("after_reset_idle", 32'({tile_valid, busy, done}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
